// File: rtl/regfile_16w_pkg.sv
// Shared definitions for the 16-entry register file and its write-select encoder.
// Holds the entry count, the index width, the select width, and the read-address type.
package regfile_16w_pkg;

    localparam int NREGS = 16;
    localparam int IDX_W = 4;
    localparam int SEL_W = 16;

    typedef logic [IDX_W-1:0] raddr_t;

endpackage

// File: rtl/regfile_16w_onehot16_enc.sv
// onehot16_enc: combinational 16-to-4 encoder with a one-hot legality check.
// Ports:
//   wsel      in   16  select vector from the write decoder
//   idx       out  4   index of the set bit (only meaningful when onehot_ok=1)
//   onehot_ok out  1   1 when exactly one bit of wsel is set
module onehot16_enc
    import regfile_16w_pkg::*;
(
    input  logic [SEL_W-1:0] wsel,
    output logic [IDX_W-1:0] idx,
    output logic             onehot_ok
);

    // OR together the indices of all set bits. For a one-hot input this is
    // exactly the index of the single set bit; for anything else the result
    // is garbage, which is harmless because onehot_ok gates every use of it.
    always_comb begin
        idx = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (wsel[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only if at most one bit was set,
    // so combining that with a non-zero check means exactly one bit is set.
    assign onehot_ok = (wsel != '0) && ((wsel & (wsel - SEL_W'(1))) == '0);

endmodule

// File: rtl/regfile_16w.sv
// regfile_16w: 16-entry register file written through a one-hot select vector.
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   we       in   1      write strobe, qualifies wsel
//   wsel     in   16     one-hot write select from the decoder
//   wdata    in   WIDTH  write data
//   raddr_a  in   4      read address, port A
//   raddr_b  in   4      read address, port B
//   rdata_a  out  WIDTH  registered read data, port A (1-cycle latency, write bypass)
//   rdata_b  out  WIDTH  registered read data, port B (1-cycle latency, write bypass)
//   sel_err  out  1      sticky: a write with a non-one-hot wsel was attempted
//   err_clr  in   1      clears sel_err (a simultaneous new error wins)
module regfile_16w
    import regfile_16w_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [SEL_W-1:0] wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             sel_err,
    input  logic             err_clr
);

    logic [WIDTH-1:0] regs [NREGS];
    raddr_t           widx;
    logic             onehot_ok;
    logic             wr_legal;
    logic             wr_commit;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    onehot16_enc u_enc (
        .wsel      (wsel),
        .idx       (widx),
        .onehot_ok (onehot_ok)
    );

    // A legal write may still be dropped when it targets the hard-wired zero
    // entry; wr_commit is the single signal that both the storage update and
    // the read bypass key off, so they can never disagree.
    assign wr_legal  = we && onehot_ok;
    assign wr_commit = wr_legal && !(ZERO_R0 && (widx == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[widx] <= wdata;
        end
    end

    // Read-data selection ahead of the output registers: a write landing on the
    // address being read this cycle forwards its data so the port sees new data.
    always_comb begin
        next_a = regs[raddr_a];
        next_b = regs[raddr_b];
        if (ZERO_R0 && (raddr_a == '0)) begin
            next_a = '0;
        end
        if (ZERO_R0 && (raddr_b == '0)) begin
            next_b = '0;
        end
        if (wr_commit && (widx == raddr_a)) begin
            next_a = wdata;
        end
        if (wr_commit && (widx == raddr_b)) begin
            next_b = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= next_a;
            rdata_b <= next_b;
        end
    end

    // Sticky error flag; a fresh illegal write takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (we && !onehot_ok) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule
